// File: rtl/uart_ctrl.sv
// Memory-mapped UART: TXD/RXD data registers and CON status/enable register.
// Define UART_PARITY_EN to add an even-parity bit to both directions (CON bit6 PARITY_ERR).
`timescale 1ns/1ps
module uart_ctrl #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(BIT_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = S_PAR;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t tx_state, tx_nx;
  state_t rx_state, rx_nx;

  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic [7:0]       tx_sh, rx_sh;
  logic [7:0]       txd, rxd;
  logic             rx_s1, rx_s2, rx_s3;
  logic             tx_ie, rx_ie, tx_done, rx_ready, overrun;
  logic             tx_busy, tx_tick, rx_tick, rx_half, rx_fall;
  logic             wr_txd, wr_con;
  logic             tx_done_set, rx_load, rx_par_ok, par_bit;
  logic             unused_wdata;

  assign unused_wdata = ^{wdata[31:8], wdata[6]};

  assign tx_busy = (tx_state != S_IDLE);
  assign tx_tick = (tx_cnt == BIT_LAST);
  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);
  assign rx_fall = rx_s3 & ~rx_s2;
  assign wr_txd  = wr & (addr == ADDR_TXD) & ~tx_busy;
  assign wr_con  = wr & (addr == ADDR_CON);

  // ---- TX state machine ----
  always_comb begin
    tx_nx       = tx_state;
    tx_done_set = 1'b0;
    unique case (tx_state)
      S_IDLE:  if (wr_txd) tx_nx = S_START;
      S_START: if (tx_tick) tx_nx = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_nx = AFTER_DATA;
      S_PAR:   if (tx_tick) tx_nx = S_STOP;
      S_STOP:  if (tx_tick) begin
        tx_nx       = S_IDLE;
        tx_done_set = 1'b1;
      end
      default: tx_nx = S_IDLE;
    endcase
  end

  // Line level decoded from registered state so reset forces idle-high at once.
  always_comb begin
    unique case (tx_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = tx_sh[0];
      S_PAR:   tx = ^txd;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= '0;
    end else begin
      tx_state <= tx_nx;
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
      else                               tx_cnt <= tx_cnt + 1'b1;
      if (wr_txd) begin
        txd    <= wdata[7:0];
        tx_sh  <= wdata[7:0];
        tx_bit <= '0;
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_bit <= tx_bit + 1'b1;
      end
    end
  end

  // ---- RX synchroniser and state machine ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

`ifdef UART_PARITY_EN
  logic par_err, par_err_set, rx_par_q;
  assign rx_par_ok = rx_par_q;
  assign par_bit   = par_err;
`else
  assign rx_par_ok = 1'b1;
  assign par_bit   = 1'b0;
`endif

  always_comb begin
    rx_nx   = rx_state;
    rx_load = 1'b0;
`ifdef UART_PARITY_EN
    par_err_set = 1'b0;
`endif
    unique case (rx_state)
      S_IDLE:  if (rx_fall) rx_nx = S_START;
      S_START: if (rx_half) rx_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = AFTER_DATA;
      S_PAR:   if (rx_tick) begin
        rx_nx = S_STOP;
`ifdef UART_PARITY_EN
        par_err_set = (rx_s2 != ^rx_sh);
`endif
      end
      S_STOP:  if (rx_tick) begin
        rx_nx   = S_IDLE;
        rx_load = rx_s2 & rx_par_ok;
      end
      default: rx_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rxd      <= '0;
    end else begin
      rx_state <= rx_nx;
      if (rx_state == S_IDLE || rx_tick || rx_nx != rx_state) rx_cnt <= '0;
      else                                                     rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_DATA && rx_tick) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
      if (rx_load) rxd <= rx_sh;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_par_q <= 1'b1;
      par_err  <= 1'b0;
    end else begin
      if (rx_state == S_PAR && rx_tick) rx_par_q <= ~par_err_set;
      par_err <= par_err_set | (par_err & ~(wr_con & ~wdata[6]));
    end
  end
`endif

  // ---- CON register and interrupt ----
  // Hardware sets are ORed after the write mask so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ie    <= 1'b0;
      rx_ie    <= 1'b0;
      tx_done  <= 1'b0;
      rx_ready <= 1'b0;
      overrun  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_con) begin
        tx_ie <= wdata[0];
        rx_ie <= wdata[1];
      end
      tx_done  <= tx_done_set | (tx_done & ~(wr_con & ~wdata[2]));
      rx_ready <= rx_load | (rx_ready & ~(wr_con & ~wdata[3]));
      overrun  <= (rx_load & rx_ready) | (overrun & ~(wr_con & ~wdata[5]));
      irq      <= (tx_ie & tx_done) | (rx_ie & rx_ready);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == ADDR_TXD)      rdata = {24'd0, txd};
      else if (addr == ADDR_RXD) rdata = {24'd0, rxd};
      else if (addr == ADDR_CON)
        rdata = {25'd0, par_bit, overrun, tx_busy, rx_ready, tx_done, rx_ie, tx_ie};
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl at BIT_DIV=16: stimulus queues expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_uart_ctrl;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;
  localparam int K_RD = 0, K_TX = 1, K_IRQ = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;
  logic        smp = 1'b0;

  always #5 clk = ~clk;

  uart_ctrl #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (rd || smp) begin
      item_t       it;
      logic [31:0] act;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        it = sbq.pop_front();
        case (it.kind)
          K_RD:    act = rdata;
          K_TX:    act = {31'd0, tx};
          default: act = {31'd0, irq};
        endcase
        n_cmp++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    sbq.push_back('{kind: K_RD, exp: e, name: nm});
    addr = a; rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic chk_pin(input int k, input logic v, input string nm);
    sbq.push_back('{kind: k, exp: {31'd0, v}, name: nm});
    smp = 1'b1;
    tick(1);
    smp = 1'b0;
  endtask

  task automatic rx_head(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stopb;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    rx_head(b, stopb);
    tick(16);
    rx = 1'b1;
    tick(4);
  endtask

  // Samples each bit mid-cell; optionally attempts a TXD write while busy.
  task automatic tx_frame(input logic [7:0] b, input logic intrude);
    bus_wr(TXD, {24'd0, b});
    tick(7);
    chk_pin(K_TX, 1'b0, "tx_start");
    if (intrude) begin
      bus_wr(TXD, 32'h55);
      bus_rd(TXD, {24'd0, b}, "txd_hold_busy");
      tick(13);
    end else begin
      tick(15);
    end
    for (int i = 0; i < 8; i++) begin
      chk_pin(K_TX, b[i], "tx_data");
      tick(15);
    end
    chk_pin(K_TX, 1'b1, "tx_stop");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    bus_rd(CON, 32'h0, "con_in_reset");
    chk_pin(K_TX, 1'b1, "tx_in_reset");
    reset = 1'b1;
    tick(2);
    bus_rd(CON, 32'h0, "con_after_reset");
    bus_rd(TXD, 32'h0, "txd_after_reset");
    bus_rd(RXD, 32'h0, "rxd_after_reset");
    chk_pin(K_TX, 1'b1, "tx_idle");
    chk_pin(K_IRQ, 1'b0, "irq_idle");

    // TX 0xA5, busy exactly 160 clocks
    tx_frame(8'hA5, 1'b0);
    tick(6);
    bus_rd(CON, 32'h10, "con_busy");
    bus_rd(CON, 32'h10, "con_busy_last");
    bus_rd(CON, 32'h04, "con_tx_done");

    // RX 0x3C, then enable both interrupts and clear RX_READY
    send_rx(8'h3C, 1'b1);
    bus_rd(CON, 32'h0C, "con_rx_ready");
    bus_rd(RXD, 32'h3C, "rxd_3c");
    chk_pin(K_IRQ, 1'b0, "irq_disabled");
    bus_wr(CON, 32'h07);
    bus_rd(CON, 32'h07, "con_w07");
    chk_pin(K_IRQ, 1'b1, "irq_tx_done");

    // RX_IE only; two bytes without clearing -> overrun
    bus_wr(CON, 32'h02);
    bus_rd(CON, 32'h02, "con_w02");
    chk_pin(K_IRQ, 1'b0, "irq_cleared");
    rx_head(8'h11, 1'b1);
    tick(10);
    chk_pin(K_IRQ, 1'b0, "irq_before_stop");
    chk_pin(K_IRQ, 1'b0, "irq_reg_delay");
    chk_pin(K_IRQ, 1'b1, "irq_rx_ready");
    tick(3);
    rx = 1'b1;
    tick(4);
    bus_rd(RXD, 32'h11, "rxd_11");
    send_rx(8'h22, 1'b1);
    bus_rd(RXD, 32'h22, "rxd_22");
    bus_rd(CON, 32'h2A, "con_overrun");
    chk_pin(K_IRQ, 1'b1, "irq_overrun");

    // False start and framing error leave state untouched
    bus_wr(CON, 32'h02);
    bus_rd(CON, 32'h02, "con_flags_cleared");
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    bus_rd(CON, 32'h02, "con_false_start");
    send_rx(8'h5A, 1'b0);
    bus_rd(RXD, 32'h22, "rxd_framing");
    bus_rd(CON, 32'h02, "con_framing");
    send_rx(8'h81, 1'b1);
    bus_rd(RXD, 32'h81, "rxd_81");
    bus_rd(CON, 32'h0A, "con_rx_again");

    // TXD write while busy is ignored
    tx_frame(8'hA5, 1'b1);
    tick(10);
    bus_rd(CON, 32'h0E, "con_tx_rx_flags");
    bus_rd(TXD, 32'hA5, "txd_a5");
    chk_pin(K_IRQ, 1'b1, "irq_rx_pending");

    // Reset mid-frame
    bus_wr(TXD, 32'hF0);
    tick(20);
    chk_pin(K_TX, 1'b0, "tx_mid_frame");
    sbq.push_back('{kind: K_TX, exp: 32'h1, name: "tx_async_reset"});
    reset = 1'b0;
    smp = 1'b1;
    tick(1);
    smp = 1'b0;
    bus_rd(CON, 32'h0, "con_mid_reset");
    bus_rd(TXD, 32'h0, "txd_mid_reset");
    bus_rd(RXD, 32'h0, "rxd_mid_reset");
    chk_pin(K_IRQ, 1'b0, "irq_mid_reset");
    reset = 1'b1;
    tick(2);
    bus_rd(CON, 32'h0, "con_post_reset");
    tick(200);
    chk_pin(K_TX, 1'b1, "tx_abandoned");

    tick(2);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
